// File: rtl/fwd_hazard_unit_v2.sv
// Operand forwarding select, held-operand capture while ID/EX is frozen,
// load-use bubble sequencing and a saturating stall-cycle counter.
module fwd_hazard_unit_v2 #(
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5,
  parameter int XLEN       = 32,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      pipe_freeze,
  input  logic                      ex_hold,
  input  logic                      if_id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] if_id_rs,
  input  logic [NUM_SRC-1:0]        if_id_uses_rs,
  input  logic                      id_ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
  input  logic [NUM_SRC-1:0]        id_ex_uses_rs,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_rdwrite,
  input  logic                      id_ex_is_load,
  input  logic                      ex_mem_valid,
  input  logic                      ex_mem_rdwrite,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      mem_wb_valid,
  input  logic                      mem_wb_rdwrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic [XLEN-1:0]           mem_wb_data,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic [NUM_SRC*XLEN-1:0]   held_data,
  output logic                      load_use_stall,
  output logic [CNT_W-1:0]          stall_count
);

  typedef enum logic [0:0] {RUN = 1'b0, LU_STALL = 1'b1} state_t;

  localparam logic [2:0] LU_INIT = 3'(LU_BUBBLES - 1);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]    held_valid_q, held_valid_d;
  logic [XLEN-1:0]       held_data_q [NUM_SRC];
  logic [XLEN-1:0]       held_data_d [NUM_SRC];
  logic [NUM_SRC-1:0]    ex_match, wb_match;
  logic                  lu_detect;

  // ID/EX advances only when neither the whole pipe nor ID/EX alone is held.
  logic id_ex_advance;
  assign id_ex_advance = !ex_hold && !pipe_freeze;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] rs;
      assign rs = id_ex_rs[gi*REG_AW +: REG_AW];

      assign ex_match[gi] = ex_mem_valid && ex_mem_rdwrite &&
                            (ex_mem_rd != '0) && (ex_mem_rd == rs);
      assign wb_match[gi] = mem_wb_valid && mem_wb_rdwrite &&
                            (mem_wb_rd != '0) && (mem_wb_rd == rs);

      always_comb begin
        fwd_sel[gi*2 +: 2] = 2'b00;
        if (id_ex_valid && id_ex_uses_rs[gi]) begin
          if (ex_match[gi])           fwd_sel[gi*2 +: 2] = 2'b01;
          else if (wb_match[gi])      fwd_sel[gi*2 +: 2] = 2'b10;
          else if (held_valid_q[gi])  fwd_sel[gi*2 +: 2] = 2'b11;
        end
      end

      // A younger MEM/WB producer during the same hold simply overwrites.
      always_comb begin
        held_valid_d[gi] = held_valid_q[gi];
        held_data_d[gi]  = held_data_q[gi];
        if (flush || id_ex_advance) begin
          held_valid_d[gi] = 1'b0;
        end else if (ex_hold && !pipe_freeze && wb_match[gi]) begin
          held_valid_d[gi] = 1'b1;
          held_data_d[gi]  = mem_wb_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          held_valid_q[gi] <= 1'b0;
          held_data_q[gi]  <= '0;
        end else begin
          held_valid_q[gi] <= held_valid_d[gi];
          held_data_q[gi]  <= held_data_d[gi];
        end
      end

      assign held_data[gi*XLEN +: XLEN] = held_data_q[gi];
    end
  endgenerate

  always_comb begin
    lu_detect = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (if_id_uses_rs[i] && (if_id_rs[i*REG_AW +: REG_AW] == id_ex_rd))
        lu_detect = 1'b1;
    end
    lu_detect = lu_detect && if_id_valid && id_ex_valid && id_ex_is_load &&
                id_ex_rdwrite && (id_ex_rd != '0);
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load_use_stall = 1'b0;
    case (state_q)
      RUN: begin
        load_use_stall = lu_detect;
        if (lu_detect && !pipe_freeze && (LU_BUBBLES > 1)) begin
          state_d = LU_STALL;
          cnt_d   = LU_INIT;
        end
      end
      LU_STALL: begin
        load_use_stall = 1'b1;
        if (!pipe_freeze) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (flush) begin
      state_d = RUN;
      cnt_d   = 3'd0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use_stall && !pipe_freeze && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit_v2.sv
// Directed bench for fwd_hazard_unit_v2 built with two load-use bubbles and a
// 4-bit stall counter so saturation is reachable quickly.
module tb_fwd_hazard_unit_v2;

  localparam int NS = 2;
  localparam int AW = 5;
  localparam int XL = 32;
  localparam int LU = 2;
  localparam int CW = 4;

  logic            clk, rst_n, flush, pipe_freeze, ex_hold;
  logic            if_id_valid;
  logic [NS*AW-1:0] if_id_rs;
  logic [NS-1:0]   if_id_uses_rs;
  logic            id_ex_valid;
  logic [NS*AW-1:0] id_ex_rs;
  logic [NS-1:0]   id_ex_uses_rs;
  logic [AW-1:0]   id_ex_rd;
  logic            id_ex_rdwrite, id_ex_is_load;
  logic            ex_mem_valid, ex_mem_rdwrite;
  logic [AW-1:0]   ex_mem_rd;
  logic            mem_wb_valid, mem_wb_rdwrite;
  logic [AW-1:0]   mem_wb_rd;
  logic [XL-1:0]   mem_wb_data;
  logic [NS*2-1:0] fwd_sel;
  logic [NS*XL-1:0] held_data;
  logic            load_use_stall;
  logic [CW-1:0]   stall_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  fwd_hazard_unit_v2 #(
    .NUM_SRC(NS), .REG_AW(AW), .XLEN(XL), .LU_BUBBLES(LU), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pipe_freeze(pipe_freeze),
    .ex_hold(ex_hold), .if_id_valid(if_id_valid), .if_id_rs(if_id_rs),
    .if_id_uses_rs(if_id_uses_rs), .id_ex_valid(id_ex_valid),
    .id_ex_rs(id_ex_rs), .id_ex_uses_rs(id_ex_uses_rs), .id_ex_rd(id_ex_rd),
    .id_ex_rdwrite(id_ex_rdwrite), .id_ex_is_load(id_ex_is_load),
    .ex_mem_valid(ex_mem_valid), .ex_mem_rdwrite(ex_mem_rdwrite),
    .ex_mem_rd(ex_mem_rd), .mem_wb_valid(mem_wb_valid),
    .mem_wb_rdwrite(mem_wb_rdwrite), .mem_wb_rd(mem_wb_rd),
    .mem_wb_data(mem_wb_data), .fwd_sel(fwd_sel), .held_data(held_data),
    .load_use_stall(load_use_stall), .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    flush = 0; pipe_freeze = 0; ex_hold = 0;
    if_id_valid = 0; if_id_rs = '0; if_id_uses_rs = '0;
    id_ex_valid = 0; id_ex_rs = '0; id_ex_uses_rs = '0; id_ex_rd = '0;
    id_ex_rdwrite = 0; id_ex_is_load = 0;
    ex_mem_valid = 0; ex_mem_rdwrite = 0; ex_mem_rd = '0;
    mem_wb_valid = 0; mem_wb_rdwrite = 0; mem_wb_rd = '0; mem_wb_data = '0;
  endtask

  task automatic setup_load_use();
    id_ex_valid = 1; id_ex_is_load = 1; id_ex_rdwrite = 1; id_ex_rd = 5'd3;
    if_id_valid = 1; if_id_uses_rs = 2'b01; if_id_rs = {5'd0, 5'd3};
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h expected 0", load_use_stall); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0h expected 0", stall_count); end
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %0h expected 0", fwd_sel); end
    checks++; if (held_data !== 64'd0) begin errors++; $display("FAIL reset_held: got %0h expected 0", held_data); end
    @(posedge clk); #2;
    rst_n = 1;
    step();
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_fwd_priority();
    idle_inputs();
    id_ex_valid = 1; id_ex_uses_rs = 2'b11; id_ex_rs = {5'd0, 5'd5};
    ex_mem_valid = 1; ex_mem_rdwrite = 1; ex_mem_rd = 5'd5;
    mem_wb_valid = 1; mem_wb_rdwrite = 1; mem_wb_rd = 5'd5;
    #1;
    checks++; if (fwd_sel[1:0] !== 2'b01) begin errors++; $display("FAIL fwd_exmem_wins: got %b expected 01", fwd_sel[1:0]); end
    ex_mem_rdwrite = 0; #1;
    checks++; if (fwd_sel[1:0] !== 2'b10) begin errors++; $display("FAIL fwd_memwb: got %b expected 10", fwd_sel[1:0]); end
    mem_wb_rdwrite = 0; #1;
    checks++; if (fwd_sel[1:0] !== 2'b00) begin errors++; $display("FAIL fwd_none: got %b expected 00", fwd_sel[1:0]); end
    ex_mem_rdwrite = 1; id_ex_uses_rs = 2'b10; #1;
    checks++; if (fwd_sel[1:0] !== 2'b00) begin errors++; $display("FAIL fwd_unused_rs: got %b expected 00", fwd_sel[1:0]); end
    id_ex_uses_rs = 2'b11; id_ex_valid = 0; #1;
    checks++; if (fwd_sel[1:0] !== 2'b00) begin errors++; $display("FAIL fwd_idex_invalid: got %b expected 00", fwd_sel[1:0]); end
    id_ex_valid = 1;
    ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] cv;
      cv = c[3:0];
      ex_mem_valid = cv[0]; ex_mem_rdwrite = cv[1];
      mem_wb_valid = cv[2]; mem_wb_rdwrite = cv[3];
      #1;
      checks++; if (fwd_sel[3:2] !== 2'b00) begin errors++; $display("FAIL fwd_x0_combo%0d: got %b expected 00", c, fwd_sel[3:2]); end
    end
    step();
    $display("test_fwd_priority done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_held();
    idle_inputs();
    id_ex_valid = 1; id_ex_uses_rs = 2'b01; id_ex_rs = {5'd0, 5'd7};
    id_ex_rd = 5'd9; id_ex_rdwrite = 1;
    ex_hold = 1;
    mem_wb_valid = 1; mem_wb_rdwrite = 1; mem_wb_rd = 5'd7; mem_wb_data = 32'hDEADBEEF;
    #1;
    checks++; if (fwd_sel[1:0] !== 2'b10) begin errors++; $display("FAIL held_c1_sel: got %b expected 10", fwd_sel[1:0]); end
    step();
    mem_wb_valid = 0; mem_wb_data = 32'h12345678;
    #1;
    checks++; if (fwd_sel[1:0] !== 2'b11) begin errors++; $display("FAIL held_c2_sel: got %b expected 11", fwd_sel[1:0]); end
    checks++; if (held_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL held_c2_data: got %h expected deadbeef", held_data[31:0]); end
    step();
    checks++; if (fwd_sel[1:0] !== 2'b11) begin errors++; $display("FAIL held_c3_sel: got %b expected 11", fwd_sel[1:0]); end
    step();
    ex_hold = 0;
    #1;
    checks++; if (fwd_sel[1:0] !== 2'b11) begin errors++; $display("FAIL held_release_cycle_sel: got %b expected 11", fwd_sel[1:0]); end
    step();
    checks++; if (fwd_sel[1:0] !== 2'b00) begin errors++; $display("FAIL held_cleared_sel: got %b expected 00", fwd_sel[1:0]); end
    checks++; if (held_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL held_data_kept: got %h expected deadbeef", held_data[31:0]); end
    $display("test_held done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_load_use();
    idle_inputs();
    setup_load_use();
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_c1: got %0h expected 1", load_use_stall); end
    step();
    id_ex_valid = 0;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_c2: got %0h expected 1", load_use_stall); end
    step();
    exp_cnt += 2;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_c3: got %0h expected 0", load_use_stall); end
    checks++; if (stall_count !== CW'(exp_cnt)) begin errors++; $display("FAIL lu_count: got %0d expected %0d", stall_count, exp_cnt); end
    $display("test_load_use done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_load_use_freeze();
    idle_inputs();
    setup_load_use();
    step();
    exp_cnt += 1;
    id_ex_valid = 0; pipe_freeze = 1;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL luf_c2: got %0h expected 1", load_use_stall); end
    step();
    pipe_freeze = 0;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL luf_c3: got %0h expected 1", load_use_stall); end
    checks++; if (stall_count !== CW'(exp_cnt)) begin errors++; $display("FAIL luf_frozen_count: got %0d expected %0d", stall_count, exp_cnt); end
    step();
    exp_cnt += 1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL luf_c4: got %0h expected 0", load_use_stall); end
    checks++; if (stall_count !== CW'(exp_cnt)) begin errors++; $display("FAIL luf_count: got %0d expected %0d", stall_count, exp_cnt); end
    $display("test_load_use_freeze done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_x0_hazard();
    idle_inputs();
    setup_load_use();
    id_ex_rd = 5'd0; if_id_rs = {5'd0, 5'd0};
    #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_x0: got %0h expected 0", load_use_stall); end
    id_ex_rd = 5'd3; if_id_rs = {5'd0, 5'd3}; if_id_uses_rs = 2'b00;
    #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_unused: got %0h expected 0", load_use_stall); end
    step();
    checks++; if (stall_count !== CW'(exp_cnt)) begin errors++; $display("FAIL lu_nohaz_count: got %0d expected %0d", stall_count, exp_cnt); end
    $display("test_x0_hazard done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_flush();
    idle_inputs();
    setup_load_use();
    step();
    exp_cnt += 1;
    id_ex_valid = 0; pipe_freeze = 1; flush = 1;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL flush_cycle_stall: got %0h expected 1", load_use_stall); end
    step();
    flush = 0;
    #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL flush_to_run: got %0h expected 0", load_use_stall); end
    pipe_freeze = 0;
    step();
    checks++; if (stall_count !== CW'(exp_cnt)) begin errors++; $display("FAIL flush_count: got %0d expected %0d", stall_count, exp_cnt); end
    $display("test_flush done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_saturate();
    idle_inputs();
    setup_load_use();
    for (int k = 0; k < 12; k++) step();
    exp_cnt = (exp_cnt + 12 > 15) ? 15 : exp_cnt + 12;
    checks++; if (stall_count !== CW'(exp_cnt)) begin errors++; $display("FAIL sat_reach: got %0d expected %0d", stall_count, exp_cnt); end
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %0h expected 1", load_use_stall); end
    step();
    step();
    checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", stall_count); end
    if_id_valid = 0;
    step();
    $display("test_saturate done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    id_ex_valid = 1; id_ex_uses_rs = 2'b01; id_ex_rs = {5'd0, 5'd7};
    id_ex_rd = 5'd3; id_ex_rdwrite = 1; id_ex_is_load = 1;
    if_id_valid = 1; if_id_uses_rs = 2'b01; if_id_rs = {5'd0, 5'd3};
    ex_hold = 1;
    mem_wb_valid = 1; mem_wb_rdwrite = 1; mem_wb_rd = 5'd7; mem_wb_data = 32'hCAFEF00D;
    step();
    mem_wb_valid = 0; if_id_valid = 0;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre_stall: got %0h expected 1", load_use_stall); end
    checks++; if (fwd_sel[1:0] !== 2'b11) begin errors++; $display("FAIL rstmid_pre_sel: got %b expected 11", fwd_sel[1:0]); end
    rst_n = 0;
    #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %0h expected 0", load_use_stall); end
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL rstmid_fwd: got %b expected 0000", fwd_sel); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", stall_count); end
    checks++; if (held_data !== 64'd0) begin errors++; $display("FAIL rstmid_held: got %h expected 0", held_data); end
    step();
    rst_n = 1;
    $display("test_reset_mid_stall done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_fwd_priority();
    test_held();
    test_load_use();
    test_load_use_freeze();
    test_x0_hazard();
    test_flush();
    test_saturate();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit_v2.md
Name: fwd_hazard_unit_v2

Overview:
- Second-generation operand forwarding and hazard controller for the 5-stage RV32I pipeline.
- Generalises the existing forwarding selection to NUM_SRC source operands.
- Adds a held-operand capture path for when ID/EX is frozen while downstream stages drain.
- Adds a parametrised load-use bubble sequencer and a saturating stall counter.
- Sits beside the ID/EX register. It drives the EX-stage operand mux selects and the IF/ID/PC stall.

Parameters:
NUM_SRC, 2, number of source operands tracked per instruction
REG_AW, 5, register address width
XLEN, 32, data width of captured writeback values
LU_BUBBLES, 1, bubble cycles inserted per load-use hazard (1..7)
CNT_W, 16, width of the stall event counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (branch/jump redirect)
pipe_freeze  in  1  all pipeline registers hold this cycle
ex_hold  in  1  ID/EX holds while EX/MEM and MEM/WB advance
if_id_valid  in  1  IF/ID holds a real instruction
if_id_rs  in  NUM_SRC*REG_AW  IF/ID source register addresses
if_id_uses_rs  in  NUM_SRC  per-source use flags (IF/ID)
id_ex_valid  in  1  ID/EX holds a real instruction
id_ex_rs  in  NUM_SRC*REG_AW  ID/EX source register addresses
id_ex_uses_rs  in  NUM_SRC  per-source use flags (ID/EX)
id_ex_rd  in  REG_AW  ID/EX destination
id_ex_rdwrite  in  1  ID/EX writes rd
id_ex_is_load  in  1  ID/EX is a load
ex_mem_valid, ex_mem_rdwrite  in  1 each  EX/MEM status
ex_mem_rd  in  REG_AW  EX/MEM destination
mem_wb_valid, mem_wb_rdwrite  in  1 each  MEM/WB status
mem_wb_rd  in  REG_AW  MEM/WB destination
mem_wb_data  in  XLEN  MEM/WB writeback value
fwd_sel  out  NUM_SRC*2  per source: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 held
held_data  out  NUM_SRC*XLEN  captured operand per source
load_use_stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
stall_count  out  CNT_W  number of load-use stall cycles

Behaviour:
- Reset (rst_n=0, async): FSM=RUN, bubble counter=0, held_valid all 0, held_data all 0, stall_count=0.
- Reset dominates all other inputs.
- fwd_sel[i] is combinational. Priority for each source i:
  - 01 if ex_mem_valid & ex_mem_rdwrite & ex_mem_rd!=0 & ex_mem_rd==id_ex_rs[i]
  - else 10 if the same conditions hold on MEM/WB
  - else 11 if held_valid[i]
  - else 00
- fwd_sel[i] is forced to 00 if !id_ex_valid or !id_ex_uses_rs[i].
- Held capture, per source, at the clock edge:
  - Capture happens when ex_hold=1, pipe_freeze=0, and the MEM/WB match condition for source i is true.
  - On capture: held_data[i]<=mem_wb_data and held_valid[i]<=1.
  - A later MEM/WB match during the same hold overwrites the held value (it is the younger producer).
  - held_valid is cleared on any edge where ID/EX advances (ex_hold=0 and pipe_freeze=0), and on flush.
  - held_data keeps its last value after held_valid is cleared.
- Load-use detect d:
  - d = if_id_valid & id_ex_valid & id_ex_is_load & id_ex_rdwrite & id_ex_rd!=0 & (id_ex_rd matches if_id_rs[i] for some i with if_id_uses_rs[i]).
- FSM states: RUN, LU_STALL.
  - RUN: load_use_stall=d. If d & !pipe_freeze & LU_BUBBLES>1: cnt<=LU_BUBBLES-1 and go to LU_STALL.
  - RUN with d & pipe_freeze: stay in RUN; d persists.
  - LU_STALL: load_use_stall=1. On each edge with !pipe_freeze, cnt decrements. When cnt==1 at an advancing edge, go to RUN.
- flush in any state: next state RUN, cnt=0. load_use_stall is still computed normally in the flush cycle.
- stall_count increments on every edge where load_use_stall=1 and pipe_freeze=0. It saturates at all-ones and does not wrap.
- Register x0 never matches for forwarding or hazard detection.

Test Plan:
- ex_mem rd=5, rdwrite=1; mem_wb rd=5; id_ex rs[0]=5 -> fwd_sel[0]=01 (EX/MEM wins); with ex_mem_rdwrite=0 -> 10.
- id_ex rs[1]=0 and every producer rd=0 -> fwd_sel[1]=00 in all combinations.
- ex_hold=1 for 3 cycles, id_ex rs[0]=7, mem_wb rd=7 data=0xDEADBEEF in cycle 1, bubble afterwards:
  - cycles 2-3: fwd_sel[0]=11, held_data[0]=0xDEADBEEF
  - after release edge: held_valid clear, fwd_sel[0]=00
- LU_BUBBLES=2, id_ex load rd=3, if_id rs[0]=3 -> load_use_stall high for exactly 2 non-frozen cycles; stall_count +2.
- Same as above, with pipe_freeze=1 in the second stall cycle -> stall extends to 3 cycles; stall_count +2 only.
- CNT_W=4, stall_count preloaded to 15 by 15 stall cycles, one more stall -> stays 15.
- rst_n dropped mid-LU_STALL with held_valid=1 -> immediately load_use_stall=0, fwd_sel=00, stall_count=0.
